// File: rtl/cic_pkg.sv
// Shared constants, types and coefficient table for the CIC compensation FIR.
// The table holds one half of the symmetric 32-tap response (Q1.15).
// The full response sums to 32768, which gives unity DC gain.
package cic_pkg;

   localparam int IW    = 19;
   localparam int OW    = 16;
   localparam int CW    = 16;
   localparam int FRAC  = 15;
   localparam int TAPS  = 32;
   localparam int DEC   = 2;
   localparam int AW    = $clog2(TAPS);
   localparam int PHW   = (DEC > 1) ? $clog2(DEC) : 1;
   localparam int ACCW  = IW + CW + AW;
   localparam int SHIFT = FRAC + IW - OW;

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_IDLE  = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   // Taps 0..15; taps 16..31 mirror them.
   localparam logic signed [CW-1:0] COEF_HALF [TAPS/2] = '{
      -16'sd7,   -16'sd21,  -16'sd29,  -16'sd15,
       16'sd24,   16'sd80,   16'sd112,  16'sd64,
      -16'sd96,  -16'sd320, -16'sd464, -16'sd320,
       16'sd320,  16'sd1600, 16'sd3312, 16'sd12144
   };

   // Symmetric lookup: for k >= TAPS/2 the mirrored index TAPS-1-k equals ~k in the low bits.
   function automatic logic signed [CW-1:0] coef_at(input logic [AW-1:0] k);
      return COEF_HALF[k[AW-1] ? ~k[AW-2:0] : k[AW-2:0]];
   endfunction

endpackage

// File: rtl/cic_comp_fir_if.sv
// Sample-stream bundle between the CIC decimator, this FIR and the output stage.
interface cic_comp_fir_if;
   import cic_pkg::*;

   logic                 i_valid;
   logic signed [IW-1:0] i_data;
   logic                 o_valid;
   logic signed [OW-1:0] o_data;
   logic                 o_busy;
   logic                 o_overrun;

   modport master (output i_valid, i_data, input o_valid, o_data, o_busy, o_overrun);
   modport slave  (input i_valid, i_data, output o_valid, o_data, o_busy, o_overrun);

endinterface

// File: rtl/fir_sample_ram.sv
// TAPS x IW sample ring: one write port and one registered read port.
// Contents are not reset; the parent zeroes them in its CLEAR state.
module fir_sample_ram
   import cic_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic signed [IW-1:0] wr_data,
   input  logic [AW-1:0]        rd_addr,
   output logic signed [IW-1:0] rd_data
);

   logic signed [IW-1:0] mem_r [TAPS];
   logic signed [IW-1:0] rd_data_r;

   // Ring write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port; read every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_r <= '0;
      end else begin
         rd_data_r <= mem_r[rd_addr];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/cic_comp_fir.sv
// Decimating CIC compensation FIR with one time-multiplexed MAC (one tap per clock).
// A one-entry skid buffer absorbs a sample that arrives while a result is being computed.
// Build option CIC_COMP_SAT_EN: when defined, the output saturates to the OW range.
// Otherwise the output keeps the low OW bits of the rounded result.
module cic_comp_fir
   import cic_pkg::*;
(
   input logic           clk,
   input logic           i_reset,
   cic_comp_fir_if.slave bus
);

   state_t                 state_r, next_state_s;
   logic [AW-1:0]          cnt_r;
   logic [AW-1:0]          wr_ptr_r;
   logic [AW-1:0]          base_r;
   logic [PHW-1:0]         phase_r;
   logic                   skid_full_r;
   logic signed [IW-1:0]   skid_data_r;
   logic signed [ACCW-1:0] acc_r;
   logic signed [CW-1:0]   coef_r;
   logic signed [IW-1:0]   rd_data_s;
   logic [AW-1:0]          rd_addr_s;
   logic                   ram_wr_en_s;
   logic [AW-1:0]          ram_wr_addr_s;
   logic signed [IW-1:0]   ram_wr_data_s;
   logic                   sample_wr_s, wrap_s, skid_load_s, skid_pop_s, drop_s;
   logic                   acc_add_s, out_en_s;
   logic signed [IW+CW-1:0] prod_s;
   logic signed [ACCW-1:0] y_s;
   logic signed [OW-1:0]   out_s;
   logic                   o_valid_r, o_busy_r, o_overrun_r;
   logic signed [OW-1:0]   o_data_r;

   localparam logic signed [ACCW-1:0] ROUND_BIAS =
      {{(ACCW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

   fir_sample_ram u_ram (
      .clk     (clk),
      .rst     (i_reset),
      .wr_en   (ram_wr_en_s),
      .wr_addr (ram_wr_addr_s),
      .wr_data (ram_wr_data_s),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   // Newest sample sits at base; tap k reads k samples back (mod TAPS).
   assign rd_addr_s = base_r - cnt_r;

   // FSM state register.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state_r <= S_CLEAR;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_CLEAR: begin
            if (cnt_r == AW'(TAPS - 1)) next_state_s = S_IDLE;
            else                        next_state_s = S_CLEAR;
         end
         S_IDLE: begin
            if (wrap_s) next_state_s = S_MAC;
            else        next_state_s = S_IDLE;
         end
         S_MAC: begin
            if (cnt_r == AW'(TAPS - 1)) next_state_s = S_DRAIN;
            else                        next_state_s = S_MAC;
         end
         S_DRAIN: next_state_s = S_OUT;
         S_OUT:   next_state_s = S_IDLE;
         default: next_state_s = S_CLEAR;
      endcase
   end

   // FSM output decode: ring writes, skid control, accumulate and output strobes.
   always_comb begin
      ram_wr_en_s   = 1'b0;
      ram_wr_addr_s = wr_ptr_r;
      ram_wr_data_s = '0;
      sample_wr_s   = 1'b0;
      wrap_s        = 1'b0;
      skid_load_s   = 1'b0;
      skid_pop_s    = 1'b0;
      drop_s        = 1'b0;
      acc_add_s     = 1'b0;
      out_en_s      = 1'b0;
      case (state_r)
         S_CLEAR: begin
            ram_wr_en_s   = 1'b1;
            ram_wr_addr_s = cnt_r;
         end
         S_IDLE: begin
            // A held skid sample is older, so it goes first; a new strobe refills the skid.
            if (skid_full_r) begin
               sample_wr_s   = 1'b1;
               ram_wr_data_s = skid_data_r;
            end else if (bus.i_valid) begin
               sample_wr_s   = 1'b1;
               ram_wr_data_s = bus.i_data;
            end else begin
               sample_wr_s   = 1'b0;
            end
            ram_wr_en_s = sample_wr_s;
            wrap_s      = sample_wr_s && (phase_r == PHW'(DEC - 1));
            skid_pop_s  = skid_full_r;
            skid_load_s = skid_full_r && bus.i_valid;
         end
         S_MAC:   acc_add_s = (cnt_r != '0);
         S_DRAIN: acc_add_s = 1'b1;
         S_OUT:   out_en_s  = 1'b1;
         default: acc_add_s = 1'b0;
      endcase
      if (state_r != S_IDLE) begin
         skid_load_s = bus.i_valid && !skid_full_r;
         drop_s      = bus.i_valid && skid_full_r;
      end else begin
         drop_s      = 1'b0;
      end
   end

   // Product of the previous cycle's sample read and coefficient.
   always_comb begin
      prod_s = (IW+CW)'(rd_data_s) * (IW+CW)'(coef_r);
   end

   // Round half up, then drop SHIFT fractional bits and narrow to OW.
   always_comb begin
      y_s = (acc_r + ROUND_BIAS) >>> SHIFT;
`ifdef CIC_COMP_SAT_EN
      if (y_s > $signed({{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}})) begin
         out_s = {1'b0, {(OW-1){1'b1}}};
      end else if (y_s < $signed({{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}})) begin
         out_s = {1'b1, {(OW-1){1'b0}}};
      end else begin
         out_s = OW'(y_s);
      end
`else
      out_s = OW'(y_s);
`endif
   end

   // Datapath: ring pointer, decimation phase, tap counter, coefficient and accumulator.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_r <= '0;
         phase_r  <= '0;
         base_r   <= '0;
         cnt_r    <= '0;
         coef_r   <= '0;
         acc_r    <= '0;
      end else begin
         if (sample_wr_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            phase_r  <= (phase_r == PHW'(DEC - 1)) ? '0 : phase_r + PHW'(1'b1);
         end
         if (wrap_s) begin
            base_r <= wr_ptr_r;
         end
         if ((state_r == S_CLEAR) || (state_r == S_MAC)) begin
            cnt_r <= cnt_r + AW'(1'b1);
         end else begin
            cnt_r <= '0;
         end
         coef_r <= coef_at(cnt_r);
         if (wrap_s) begin
            acc_r <= '0;
         end else if (acc_add_s) begin
            acc_r <= acc_r + ACCW'(prod_s);
         end
      end
   end

   // One-entry skid buffer for samples that arrive while not IDLE.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         skid_full_r <= 1'b0;
         skid_data_r <= '0;
      end else if (skid_load_s) begin
         skid_full_r <= 1'b1;
         skid_data_r <= bus.i_data;
      end else if (skid_pop_s) begin
         skid_full_r <= 1'b0;
      end
   end

   // Registered outputs: result strobe, held data, busy flag and sticky overrun.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         o_valid_r   <= 1'b0;
         o_data_r    <= '0;
         o_busy_r    <= 1'b1;
         o_overrun_r <= 1'b0;
      end else begin
         o_valid_r <= out_en_s;
         if (out_en_s) begin
            o_data_r <= out_s;
         end
         o_busy_r <= (next_state_s != S_IDLE);
         if (drop_s) begin
            o_overrun_r <= 1'b1;
         end
      end
   end

   assign bus.o_valid   = o_valid_r;
   assign bus.o_data    = o_data_r;
   assign bus.o_busy    = o_busy_r;
   assign bus.o_overrun = o_overrun_r;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir: behavioural FIR/decimator model fed by
// directed and $urandom stimulus, plus reset, latency, overrun and abort checks.
module tb_cic_comp_fir;

   localparam int TW    = 19;
   localparam int NTAPS = 32;
   localparam int NDEC  = 2;
   localparam int SH    = 18;
   localparam int LAT   = NTAPS + 2;

   logic clk = 1'b0;
   logic i_reset = 1'b1;
   always #5 clk = ~clk;

   cic_comp_fir_if bus ();

   cic_comp_fir dut (
      .clk     (clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   int     n_cmp = 0;
   int     n_err = 0;
   int     cyc = 0;
   int     valid_cnt = 0;
   int     last_valid_cyc = 0;
   int     last_trig_cyc = 0;
   longint last_data = 0;
   longint coef [NTAPS];
   longint hist_q [$];
   longint exp_q [$];
   int     model_phase = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference: y[n] = sum_k coef[k]*x[n-k], evaluated every DEC-th written sample.
   function automatic void model_reset();
      exp_q.delete();
      hist_q.delete();
      for (int i = 0; i < NTAPS; i++) hist_q.push_back(0);
      model_phase = 0;
   endfunction

   function automatic void model_write(input longint x);
      longint acc;
      longint y;
      hist_q.push_back(x);
      hist_q.delete(0);
      model_phase++;
      if (model_phase == NDEC) begin
         model_phase = 0;
         acc = 0;
         for (int k = 0; k < NTAPS; k++) acc += coef[k] * hist_q[NTAPS-1-k];
         y = (acc + (64'sd1 <<< (SH-1))) >>> SH;
`ifdef CIC_COMP_SAT_EN
         if (y > 32767) y = 32767;
         else if (y < -32768) y = -32768;
`else
         y = ((y + 32768) & 65535) - 32768;
`endif
         exp_q.push_back(y);
         last_trig_cyc = cyc;
      end
   endfunction

   // Output monitor: every o_valid pulse must match the next model result.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.o_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            last_data = bus.o_data;
            if (exp_q.size() > 0) check("o_data", bus.o_data, exp_q.pop_front());
            else                  check("unexpected_o_valid", bus.o_valid, 1'b0);
         end
      end
   end

   // Present one sample for one clock (called on a negedge), then idle until gap clocks elapsed.
   task automatic send(input longint x, input int gap);
      bus.i_valid = 1'b1;
      bus.i_data  = TW'(x);
      @(negedge clk);
      bus.i_valid = 1'b0;
      model_write(x);
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic do_reset();
      int n;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      i_reset     = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_o_valid", bus.o_valid, 1'b0);
      check("rst_o_data", bus.o_data, 0);
      check("rst_o_busy", bus.o_busy, 1'b1);
      check("rst_o_overrun", bus.o_overrun, 1'b0);
      i_reset = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.o_busy && n < 100);
      check("busy_after_reset", n, NTAPS);
   endtask

   task automatic align_phase();
      while (model_phase != NDEC - 1) send(0, 40);
   endtask

   initial begin
      longint half [NTAPS/2] = '{-7, -21, -29, -15, 24, 80, 112, 64,
                                 -96, -320, -464, -320, 320, 1600, 3312, 12144};
      logic signed [TW-1:0] v;
      int vc;
      for (int k = 0; k < NTAPS; k++) coef[k] = (k < NTAPS/2) ? half[k] : half[NTAPS-1-k];
      bus.i_valid = 1'b0;
      bus.i_data  = '0;

      do_reset();

      // Impulse: outputs walk the odd taps, halved and rounded, then zero.
      send(131072, 40);
      check("no_early_valid", valid_cnt, 0);
      send(0, 40);
      check("latency", last_valid_cyc - last_trig_cyc, LAT);
      for (int i = 0; i < 32; i++) send(0, 40);

      // DC 1000: settles at 125.
      for (int i = 0; i < 40; i++) send(1000, 40);
      check("dc_1000", last_data, 125);

      // Full-scale DC.
      for (int i = 0; i < 40; i++) send(262143, 40);
`ifdef CIC_COMP_SAT_EN
      check("dc_full_scale", last_data, 32767);
`else
      check("dc_full_scale", last_data, -32768);
`endif

      // Random samples, random spacing without skid pressure.
      for (int i = 0; i < 60; i++) begin
         v = TW'($urandom);
         send(v, $urandom_range(36, 50));
      end

      // Three back-to-back strobes: first triggers MAC, second to skid, third dropped.
      check("overrun_clear", bus.o_overrun, 1'b0);
      align_phase();
      bus.i_valid = 1'b1;
      bus.i_data  = TW'(4000);
      @(negedge clk);
      model_write(4000);
      bus.i_data  = TW'(-3000);
      @(negedge clk);
      model_write(-3000);
      bus.i_data  = TW'(77777);
      @(negedge clk);
      bus.i_valid = 1'b0;
      check("overrun_set", bus.o_overrun, 1'b1);
      repeat (45) @(negedge clk);
      check("overrun_held", bus.o_overrun, 1'b1);
      for (int i = 0; i < 4; i++) send(500 * (i + 1), 40);
      check("overrun_held_late", bus.o_overrun, 1'b1);

      // Reset in the middle of MAC: the in-flight result must never appear.
      align_phase();
      send(12345, 10);
      vc = valid_cnt;
      do_reset();
      repeat (40) @(negedge clk);
      check("abort_no_valid", valid_cnt, vc);
      check("abort_o_data", bus.o_data, 0);
      for (int i = 0; i < 40; i++) send(1000, 40);
      check("dc_after_abort", last_data, 125);

      repeat (10) @(negedge clk);
      check("pending_outputs", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
